// File: rtl/seg_scan_decoder_if.sv
// rtl/seg_scan_decoder_if.sv - 7-segment scan link bundle (optional dp lane under SEGDEC_DP_EN)
interface seg_scan_decoder_if #(
  parameter int NDIG = 4
);
  logic [7:0]        seg;
  logic [NDIG-1:0]   an;
  logic              err_clr;
  logic [4*NDIG-1:0] digits;
  logic [NDIG-1:0]   valid;
  logic              upd;
  logic              err;
  logic              err_flag;
`ifdef SEGDEC_DP_EN
  logic [NDIG-1:0]   dp;

  modport master (
    output seg, an, err_clr,
    input  digits, valid, upd, err, err_flag, dp
  );

  modport slave (
    input  seg, an, err_clr,
    output digits, valid, upd, err, err_flag, dp
  );
`else
  modport master (
    output seg, an, err_clr,
    input  digits, valid, upd, err, err_flag
  );

  modport slave (
    input  seg, an, err_clr,
    output digits, valid, upd, err, err_flag
  );
`endif
endinterface

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - scanned 7-segment receiver, nibble recovery; SEGDEC_DP_EN adds dp capture
module seg_scan_decoder #(
  parameter int NDIG   = 4,
  parameter int STABLE = 4
) (
  input  logic               clk,
  input  logic               reset,
  seg_scan_decoder_if.slave  bus
);

  localparam int CW = $clog2(STABLE + 1);
  localparam int SW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE);
  localparam logic [CW-1:0] CNT_CAP = CW'(STABLE - 1);

  logic [7:0]        seg_m, seg_s;
  logic [NDIG-1:0]   an_m, an_s;
  logic [NDIG+7:0]   prev;
  logic [CW-1:0]     cnt;
  logic              same;
  logic [3:0]        zeros;
  logic [SW-1:0]     sel;
  logic [7:0]        key;
  logic              hit;
  logic              blank;
  logic [3:0]        nib;
  logic              capture;
  logic              bad;

  logic [4*NDIG-1:0] digits_r;
  logic [NDIG-1:0]   valid_r;
  logic              upd_r;
  logic              err_r;
  logic              err_flag_r;

  // two-flop synchronizer; idles at blank segments with no anode selected
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_m <= '1;
      an_m  <= '1;
      seg_s <= '1;
      an_s  <= '1;
    end else begin
      seg_m <= bus.seg;
      an_m  <= bus.an;
      seg_s <= seg_m;
      an_s  <= an_m;
    end
  end

  assign same = ({seg_s, an_s} == prev);

  // stability window: restart on any change, saturate so a held input captures once
  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= '1;
      cnt  <= '0;
    end else if (!same) begin
      prev <= {seg_s, an_s};
      cnt  <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  // count low anodes and remember which one is low
  always_comb begin
    zeros = 4'd0;
    sel   = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (!an_s[i]) begin
        zeros = zeros + 4'd1;
        sel   = SW'(i);
      end
    end
  end

  // segment code table; with dp lane enabled the DP bit is forced off before matching
  always_comb begin
`ifdef SEGDEC_DP_EN
    key = {1'b1, seg_s[6:0]};
`else
    key = seg_s;
`endif
    hit = 1'b1;
    nib = 4'h0;
    case (key)
      8'h88: nib = 4'h0;
      8'hBB: nib = 4'h1;
      8'hC2: nib = 4'h2;
      8'h92: nib = 4'h3;
      8'hB1: nib = 4'h4;
      8'h94: nib = 4'h5;
      8'h84: nib = 4'h6;
      8'hB8: nib = 4'h7;
      8'h80: nib = 4'h8;
      8'h90: nib = 4'h9;
      8'hA0: nib = 4'hA;
      8'h85: nib = 4'hB;
      8'hCC: nib = 4'hC;
      8'h83: nib = 4'hD;
      8'hC4: nib = 4'hE;
      8'hE4: nib = 4'hF;
      default: hit = 1'b0;
    endcase
    blank = (key == 8'hFF);
  end

  assign capture = same && (cnt == CNT_CAP) && (zeros == 4'd1);
  assign bad     = capture && !hit && !blank;

  // capture results into the selected digit slot and raise the event pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      digits_r   <= '0;
      valid_r    <= '0;
      upd_r      <= 1'b0;
      err_r      <= 1'b0;
      err_flag_r <= 1'b0;
    end else begin
      upd_r <= 1'b0;
      err_r <= 1'b0;
      if (capture) begin
        if (hit) begin
          digits_r[{sel, 2'b00} +: 4] <= nib;
          valid_r[sel]                <= 1'b1;
          upd_r                       <= 1'b1;
        end else begin
          valid_r[sel] <= 1'b0;
          err_r        <= !blank;
        end
      end
      if (bad) begin
        err_flag_r <= 1'b1;
      end else if (bus.err_clr) begin
        err_flag_r <= 1'b0;
      end
    end
  end

`ifdef SEGDEC_DP_EN
  logic [NDIG-1:0] dp_r;

  // decimal point follows each match or blank capture of its digit
  always_ff @(posedge clk) begin
    if (reset) begin
      dp_r <= '0;
    end else if (capture && (hit || blank)) begin
      dp_r[sel] <= ~seg_s[7];
    end
  end

  assign bus.dp = dp_r;
`endif

  assign bus.digits   = digits_r;
  assign bus.valid    = valid_r;
  assign bus.upd      = upd_r;
  assign bus.err      = err_r;
  assign bus.err_flag = err_flag_r;

endmodule
